timer_bamse: RTL and testbench
==============================

# timer_bamse

Memory-mapped 16-bit up-counting timer with a 3-bit power-of-two prescaler, one-shot or auto-reload mode, and a sticky interrupt flag. It sits on the processor's 8-bit port bus at address `ADDR`. Software configures and starts it with a port write, and reads status with a port read. The interrupt is cleared by that read.

## Interface
- `ADDR`, default 8'h00: port address of the config/status register.

- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `timer_conf` in 16: reload/start value of the counter.
- `address` in 8: port address.
- `config_in` in 8: write data. The fields are:
  - [7] reserved (ignored)
  - [6:4] prescaler
  - [3] auto_load
  - [2] en
  - [1] go
  - [0] ignored
- `wen` in 1: write strobe, sampled on a rising edge.
- `ren` in 1: read strobe.
- `config_out` out 8: read data `{1'b0, prescaler, auto_load, en, running, irq}` when `ren && address==ADDR`, otherwise 8'h00.
- `tmr_interrupt` out 1: sticky interrupt flag `irq`.

## Operation
- Internal state:
  - `prescaler` (3 bits), `auto_load`, `en`
  - `running`
  - `irq`
  - `count` (16 bits)
  - `pcount` (7 bits)
- A write occurs when `wen && address==ADDR` at a rising edge. On a write:
  - `prescaler`, `auto_load` and `en` are loaded from `config_in[6:2]`.
  - `pcount` is set to 0.
  - If `config_in[1]` is 1: `count` is set to `timer_conf` and `running` is set to 1. This is a (re)start, including when already running.
  - If `config_in[1]` is 0: `running` is set to 0 (stop). `count` holds.
- Prescaling, evaluated when `running && en` and no write occurs that cycle:
  - `pcount` increments every clock.
  - A tick occurs when `pcount == 2^prescaler - 1`, and `pcount` then returns to 0.
  - `prescaler` = 0 gives a tick every clock; `prescaler` = 7 gives a tick every 128 clocks.
- On a tick with `count != 16'hFFFF`, `count` is incremented by 1.
- On a tick with `count == 16'hFFFF` (overflow):
  - `irq` is set to 1.
  - If `auto_load` is 1: `count` is set to `timer_conf` and counting continues.
  - If `auto_load` is 0: `running` is set to 0 and `count` stays at 16'hFFFF.
- `en` = 0 while running pauses the timer: `count` and `pcount` hold, and `running` stays 1.
- `irq` is cleared at the rising edge where `ren && address==ADDR`. `config_out` shows the pre-clear value during that read.
- Simultaneous overflow set and read clear in the same cycle: the set wins, so `irq` stays 1.
- `config_in[0]` is ignored. Writes never change `irq`.
- Accesses with `address != ADDR` have no effect, and `config_out` is 8'h00 for them.

## Timing
- Reset (`rst` = 0, asynchronous) forces every register to 0: `prescaler`, `auto_load`, `en`, `running`, `irq`, `count`, `pcount`. As a result `tmr_interrupt` = 0 and `config_out` = 8'h00.
- Reset mid-count aborts the count immediately.
- Write latency: the new config and start take effect at the write edge. The first count increment occurs 2^prescaler edges after that.
- One-shot latency: `tmr_interrupt` rises at a rising edge N·2^p clocks after the write edge, where N = 16'h10000 − `timer_conf` and p = `prescaler`.
  - Example: `timer_conf` = 16'hFFF0, p = 0 gives an interrupt 16 clocks after the write.
- `config_out` is combinational from the strobe, the address and the current register values (zero-cycle read).
- `tmr_interrupt` is registered (rising edge only).
- `timer_conf` is sampled only at start and at auto-reload.

## Test plan
- Reset: hold `rst` = 0 → `tmr_interrupt` = 0, and a read (`ren`, addr 0) gives 8'h00.
- One-shot: `timer_conf` = 16'hFFF0, write 8'h06 (en = 1, go = 1, p = 0) → `tmr_interrupt` rises exactly 16 clocks later. A read then returns 8'h05, and after the read edge `tmr_interrupt` = 0.
- Prescale: `timer_conf` = 16'hFFFE, write 8'h26 (p = 2) → interrupt 8 clocks after the write. Clearing `en` via write 8'h22 mid-count holds `count` frozen.
- Auto-reload: `timer_conf` = 16'hFFFC, write 8'h0E → the first interrupt occurs at 4 clocks. After a read-clear, the interrupt recurs every 4 clocks. A read shows `running` = 1 (8'h0E or 8'h0F).
- Address decode: with `ADDR` = 8'h10, write 8'h06 at address 8'h00 → no start and no interrupt. A read at a non-matching address gives 8'h00.
- Collision: a read-clear on the same edge as an overflow leaves `tmr_interrupt` = 1. A restart write while running reloads `timer_conf` and re-times the full period.

Source files
------------

// File: rtl/timer_bamse.sv
// timer_bamse: 16-bit up-counting port-mapped timer with a power-of-two
// prescaler, one-shot or auto-reload mode and a sticky interrupt flag that
// is cleared by reading the config/status register.

module timer_bamse #(
   parameter logic [7:0] ADDR = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] timer_conf,
   input  logic [7:0]  address,
   input  logic [7:0]  config_in,
   input  logic        wen,
   input  logic        ren,
   output logic [7:0]  config_out,
   output logic        tmr_interrupt
);

   logic [2:0]  prescaler_q, prescaler_d;
   logic        autoLoad_q, autoLoad_d;
   logic        en_q, en_d;
   logic        running_q, running_d;
   logic        irq_q, irq_d;
   logic [15:0] count_q, count_d;
   logic [6:0]  pcount_q, pcount_d;

   logic        writeHit;
   logic        readHit;
   logic        advance;
   logic        tick;
   logic        overflow;
   logic [6:0]  pLimit;
   logic        unusedCfg;

   // Bit 7 is reserved and bit 0 has no function; they are folded away here.
   assign unusedCfg = config_in[7] ^ config_in[0];

   // Bus decode and prescaler tick; a write in the same cycle always
   // overrides counting so software sees its config take effect at once.
   always_comb begin
      writeHit = wen && (address == ADDR);
      readHit  = ren && (address == ADDR);
      pLimit   = 7'h7F >> (3'd7 - prescaler_q);
      advance  = running_q && en_q && !writeHit;
      tick     = advance && (pcount_q == pLimit);
      overflow = tick && (count_q == 16'hFFFF);
   end

   // Next-state logic for configuration, run state, counter and prescaler.
   always_comb begin
      prescaler_d = prescaler_q;
      autoLoad_d  = autoLoad_q;
      en_d        = en_q;
      running_d   = running_q;
      count_d     = count_q;
      pcount_d    = pcount_q;
      if (writeHit) begin
         prescaler_d = config_in[6:4];
         autoLoad_d  = config_in[3];
         en_d        = config_in[2];
         pcount_d    = 7'd0;
         if (config_in[1]) begin
            count_d   = timer_conf;
            running_d = 1'b1;
         end else begin
            running_d = 1'b0;
         end
      end else if (advance) begin
         if (tick) begin
            pcount_d = 7'd0;
            if (overflow) begin
               if (autoLoad_q) begin
                  count_d = timer_conf;
               end else begin
                  running_d = 1'b0;
               end
            end else begin
               count_d = count_q + 16'd1;
            end
         end else begin
            pcount_d = pcount_q + 7'd1;
         end
      end
   end

   // Sticky interrupt: overflow sets it and beats a simultaneous read-clear.
   always_comb begin
      irq_d = irq_q;
      if (overflow) begin
         irq_d = 1'b1;
      end else if (readHit) begin
         irq_d = 1'b0;
      end
   end

   // State registers, all cleared by the asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prescaler_q <= 3'd0;
         autoLoad_q  <= 1'b0;
         en_q        <= 1'b0;
         running_q   <= 1'b0;
         irq_q       <= 1'b0;
         count_q     <= 16'd0;
         pcount_q    <= 7'd0;
      end else begin
         prescaler_q <= prescaler_d;
         autoLoad_q  <= autoLoad_d;
         en_q        <= en_d;
         running_q   <= running_d;
         irq_q       <= irq_d;
         count_q     <= count_d;
         pcount_q    <= pcount_d;
      end
   end

   // Zero-cycle status read; shows the interrupt value before it is cleared.
   always_comb begin
      config_out = 8'h00;
      if (readHit) begin
         config_out = {1'b0, prescaler_q, autoLoad_q, en_q, running_q, irq_q};
      end
   end

   assign tmr_interrupt = irq_q;

endmodule

// File: tb/tb_timer_bamse.sv
// tb_timer_bamse: scenario tasks plus randomized one-shot/auto-reload runs
// whose expected interrupt timing comes from the closed-form period rule.

module tb_timer_bamse;

   localparam logic [7:0] A = 8'h10;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] timer_conf;
   logic [7:0]  address;
   logic [7:0]  config_in;
   logic        wen;
   logic        ren;
   logic [7:0]  config_out;
   logic        tmr_interrupt;

   int tests = 0;
   int fails = 0;

   timer_bamse #(.ADDR(A)) dut (
      .clk(clk),
      .rst(rst),
      .timer_conf(timer_conf),
      .address(address),
      .config_in(config_in),
      .wen(wen),
      .ren(ren),
      .config_out(config_out),
      .tmr_interrupt(tmr_interrupt)
   );

   // 10 ns free-running clock.
   always #5 clk = ~clk;

   // Edges from a write until the interrupt rises: (2^16 - conf) * 2^p.
   function automatic int irqEdge(input logic [15:0] conf, input int p);
      return (32'h10000 - int'(conf)) << p;
   endfunction

   function automatic logic [7:0] statusByte(input int p, input bit al, input bit en,
                                             input bit run, input bit irq);
      logic [2:0] pb;
      pb = 3'(p);
      return {1'b0, pb, al, en, run, irq};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
      address   = a;
      config_in = d;
      wen       = 1'b1;
      step();
      wen       = 1'b0;
      address   = 8'h00;
   endtask

   // Stop the timer and read-clear the interrupt so each scenario starts idle.
   task automatic clearAll();
      doWrite(A, 8'h00);
      ren     = 1'b1;
      address = A;
      step();
      ren     = 1'b0;
      address = 8'h00;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      tests++;
      if (tmr_interrupt !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_irq got=%0b exp=0", tmr_interrupt);
      end
      ren = 1'b1; address = A; #1;
      tests++;
      if (config_out !== 8'h00) begin
         fails++;
         $display("[TB] FAIL reset_read got=%h exp=00", config_out);
      end
      ren = 1'b0; address = 8'h00;
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_reset_midcount();
      clearAll();
      timer_conf = 16'hFFF0;
      doWrite(A, 8'h06);
      for (int i = 0; i < 5; i++) step();
      ren = 1'b1; address = A;
      #2 rst = 1'b0;
      #1;
      tests++;
      if (config_out !== 8'h00) begin
         fails++;
         $display("[TB] FAIL midreset_read got=%h exp=00", config_out);
      end
      ren = 1'b0; address = 8'h00;
      step();
      rst = 1'b1;
      for (int i = 0; i < 30; i++) step();
      tests++;
      if (tmr_interrupt !== 1'b0) begin
         fails++;
         $display("[TB] FAIL midreset_abort irq=%0b exp=0", tmr_interrupt);
      end
   endtask

   task automatic test_one_shot();
      int edgeAt;
      clearAll();
      timer_conf = 16'hFFF0;
      edgeAt = irqEdge(16'hFFF0, 0);
      doWrite(A, 8'h06);
      for (int j = 1; j <= 20; j++) begin
         step();
         tests++;
         if (tmr_interrupt !== (j >= edgeAt)) begin
            fails++;
            $display("[TB] FAIL oneshot_edge j=%0d got=%0b exp=%0b", j, tmr_interrupt, j >= edgeAt);
         end
      end
      ren = 1'b1; address = A; #1;
      tests++;
      if (config_out !== 8'h05) begin
         fails++;
         $display("[TB] FAIL oneshot_read got=%h exp=05", config_out);
      end
      step();
      ren = 1'b0; address = 8'h00;
      tests++;
      if (tmr_interrupt !== 1'b0) begin
         fails++;
         $display("[TB] FAIL oneshot_clear got=%0b exp=0", tmr_interrupt);
      end
   endtask

   task automatic test_prescale();
      int edgeAt;
      clearAll();
      timer_conf = 16'hFFFE;
      edgeAt = irqEdge(16'hFFFE, 2);
      doWrite(A, 8'h26);
      for (int j = 1; j <= 10; j++) begin
         step();
         tests++;
         if (tmr_interrupt !== (j >= edgeAt)) begin
            fails++;
            $display("[TB] FAIL prescale_edge j=%0d got=%0b exp=%0b", j, tmr_interrupt, j >= edgeAt);
         end
      end
      ren = 1'b1; address = A; #1;
      tests++;
      if (config_out !== statusByte(2, 0, 1, 0, 1)) begin
         fails++;
         $display("[TB] FAIL prescale_read got=%h exp=%h", config_out, statusByte(2, 0, 1, 0, 1));
      end
      step();
      ren = 1'b0; address = 8'h00;
      // Start with en=0 one tick away from overflow: nothing may happen.
      timer_conf = 16'hFFFF;
      doWrite(A, 8'h22);
      for (int j = 0; j < 40; j++) step();
      tests++;
      if (tmr_interrupt !== 1'b0) begin
         fails++;
         $display("[TB] FAIL pause_frozen irq=%0b exp=0", tmr_interrupt);
      end
      ren = 1'b1; address = A; #1;
      tests++;
      if (config_out !== 8'h22) begin
         fails++;
         $display("[TB] FAIL pause_read got=%h exp=22", config_out);
      end
      step();
      ren = 1'b0; address = 8'h00;
      doWrite(A, 8'h26);
      for (int j = 1; j <= 5; j++) begin
         step();
         tests++;
         if (tmr_interrupt !== (j >= 4)) begin
            fails++;
            $display("[TB] FAIL pause_resume j=%0d got=%0b exp=%0b", j, tmr_interrupt, j >= 4);
         end
      end
   endtask

   task automatic test_auto_reload_and_collision();
      clearAll();
      timer_conf = 16'hFFFC;
      doWrite(A, 8'h0E);
      for (int j = 1; j <= 4; j++) begin
         step();
         tests++;
         if (tmr_interrupt !== (j >= 4)) begin
            fails++;
            $display("[TB] FAIL auto_first j=%0d got=%0b exp=%0b", j, tmr_interrupt, j >= 4);
         end
      end
      for (int k = 0; k < 3; k++) begin
         ren = 1'b1; address = A; #1;
         tests++;
         if (config_out !== 8'h0F) begin
            fails++;
            $display("[TB] FAIL auto_read k=%0d got=%h exp=0f", k, config_out);
         end
         step();
         ren = 1'b0; address = 8'h00;
         for (int off = 1; off <= 4; off++) begin
            if (off > 1) step();
            tests++;
            if (tmr_interrupt !== (off == 4)) begin
               fails++;
               $display("[TB] FAIL auto_period k=%0d off=%0d got=%0b exp=%0b", k, off, tmr_interrupt, off == 4);
            end
         end
      end
      // Hold the read strobe across the next overflow edge: set must win.
      ren = 1'b1; address = A;
      for (int off = 1; off <= 4; off++) begin
         if (off == 4) begin
            tests++;
            if (config_out !== 8'h0E) begin
               fails++;
               $display("[TB] FAIL collide_read got=%h exp=0e", config_out);
            end
         end
         step();
         tests++;
         if (tmr_interrupt !== (off == 4)) begin
            fails++;
            $display("[TB] FAIL collide_irq off=%0d got=%0b exp=%0b", off, tmr_interrupt, off == 4);
         end
      end
      ren = 1'b0; address = 8'h00;
   endtask

   task automatic test_back_to_back();
      clearAll();
      timer_conf = 16'hFFF0;
      doWrite(A, 8'h06);
      for (int i = 0; i < 5; i++) step();
      timer_conf = 16'hFFF8;
      doWrite(A, 8'h06);
      for (int j = 1; j <= 9; j++) begin
         step();
         tests++;
         if (tmr_interrupt !== (j >= 8)) begin
            fails++;
            $display("[TB] FAIL restart j=%0d got=%0b exp=%0b", j, tmr_interrupt, j >= 8);
         end
      end
   endtask

   task automatic test_address_decode();
      clearAll();
      timer_conf = 16'hFFFF;
      doWrite(8'h00, 8'h06);
      for (int i = 0; i < 20; i++) step();
      tests++;
      if (tmr_interrupt !== 1'b0) begin
         fails++;
         $display("[TB] FAIL decode_nostart irq=%0b exp=0", tmr_interrupt);
      end
      ren = 1'b1; address = A; #1;
      tests++;
      if (config_out !== 8'h00) begin
         fails++;
         $display("[TB] FAIL decode_cfg got=%h exp=00", config_out);
      end
      ren = 1'b0; address = 8'h00;
      doWrite(A, 8'h06);
      step();
      ren = 1'b1; address = 8'h20; #1;
      tests++;
      if (config_out !== 8'h00) begin
         fails++;
         $display("[TB] FAIL decode_otheraddr got=%h exp=00", config_out);
      end
      step();
      ren = 1'b0; address = 8'h00;
      tests++;
      if (tmr_interrupt !== 1'b1) begin
         fails++;
         $display("[TB] FAIL decode_noclear irq=%0b exp=1", tmr_interrupt);
      end
   endtask

   task automatic test_random();
      logic [15:0] conf;
      int p;
      bit al;
      int edgeAt;
      for (int it = 0; it < 16; it++) begin
         clearAll();
         conf = 16'hFFFF - 16'($urandom_range(0, 30));
         p    = int'($urandom_range(0, 3));
         al   = 1'($urandom_range(0, 1));
         edgeAt = irqEdge(conf, p);
         timer_conf = conf;
         doWrite(A, statusByte(p, al, 1, 1, 0));
         for (int j = 1; j <= edgeAt + 2; j++) begin
            step();
            tests++;
            if (tmr_interrupt !== (j >= edgeAt)) begin
               fails++;
               $display("[TB] FAIL rand_edge it=%0d conf=%h p=%0d al=%0b j=%0d got=%0b exp=%0b",
                        it, conf, p, al, j, tmr_interrupt, j >= edgeAt);
            end
         end
         ren = 1'b1; address = A; #1;
         tests++;
         if (config_out !== statusByte(p, al, 1, al, 1)) begin
            fails++;
            $display("[TB] FAIL rand_read it=%0d got=%h exp=%h", it, config_out, statusByte(p, al, 1, al, 1));
         end
         ren = 1'b0; address = 8'h00;
      end
   endtask

   initial begin
      rst        = 1'b0;
      timer_conf = 16'h0000;
      address    = 8'h00;
      config_in  = 8'h00;
      wen        = 1'b0;
      ren        = 1'b0;
      test_reset();
      test_one_shot();
      test_prescale();
      test_auto_reload_and_collision();
      test_back_to_back();
      test_address_decode();
      test_reset_midcount();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
